// File: rtl/hnoc_port_arbiter.sv
// Output-port arbiter for one HNoC switch port: round-robin grant with a per-grant burst limit.
// Define HNOC_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module hnoc_port_arbiter #(
    parameter int DataWidth = 36,
    parameter int AddrWidth = 4,
    parameter int NumReq    = 3,
    parameter int MaxBurst  = 4
) (
    input  logic                        i_mclk,
    input  logic                        i_reset,
    input  logic [NumReq*DataWidth-1:0] i_req_data,
    input  logic [NumReq-1:0]           i_req_valid,
    output logic [NumReq-1:0]           o_req_ready,
    output logic [DataWidth-1:0]        o_data,
    output logic                        o_data_valid,
    input  logic                        i_data_ready,
    output logic [NumReq-1:0]           o_grant,
    output logic                        o_busy
);

    localparam int              IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [3:0]      LastBeat = 4'(MaxBurst - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumReq - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [IdxW-1:0] g_reg, g_next;
    logic [IdxW-1:0] p_reg, p_next;
    logic [3:0]      bc_reg, bc_next;
    logic [IdxW-1:0] rr_ptr;
    logic [NumReq-1:0] grant_vec;
    logic [DataWidth-1:0] sel_data;
    logic            busy;
    logic            valid_g;
    logic            xfer;
    logic            release_grant;

    // First valid requester at or after start, wrapping modulo NumReq.
    function automatic logic [IdxW-1:0] pick_from(input logic [NumReq-1:0] vld,
                                                  input logic [IdxW-1:0]   start);
        logic [IdxW-1:0]   sel;
        logic [NumReq-1:0] rot;
        logic              found;
        int                idx;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            idx = int'(start) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            rot = vld >> idx;
            if (!found && rot[0]) begin
                sel   = IdxW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign busy = (state_reg == ST_GRANT);

    genvar gi;
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_req
            assign grant_vec[gi] = busy && (g_reg == IdxW'(gi));
        end
    endgenerate

    always_comb begin
        sel_data = i_req_data[DataWidth-1:0];
        valid_g  = 1'b0;
        for (int r = 0; r < NumReq; r++) begin
            if (g_reg == IdxW'(r)) begin
                sel_data = i_req_data[r*DataWidth +: DataWidth];
                valid_g  = i_req_valid[r];
            end
        end
    end

    // Address field and payload travel together unmodified.
    assign o_data       = {sel_data[DataWidth-1 -: AddrWidth], sel_data[DataWidth-AddrWidth-1:0]};
    assign o_data_valid = busy && valid_g;
    assign o_req_ready  = grant_vec & {NumReq{i_data_ready}};
    assign o_grant      = grant_vec;
    assign o_busy       = busy;
    assign xfer         = o_data_valid && i_data_ready;

`ifdef HNOC_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    assign rr_ptr = (g_reg == LastIdx) ? '0 : g_reg + IdxW'(1);
`endif

    always_comb begin
        state_next    = state_reg;
        g_next        = g_reg;
        p_next        = p_reg;
        bc_next       = bc_reg;
        release_grant = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    state_next = ST_GRANT;
                    g_next     = pick_from(i_req_valid, p_reg);
                    bc_next    = '0;
                end
            end
            ST_GRANT: begin
                // A pending beat (valid without ready) is never preempted.
                if (xfer && (bc_reg == LastBeat)) begin
                    release_grant = 1'b1;
                end else if (!valid_g) begin
                    release_grant = 1'b1;
                end else if (xfer) begin
                    bc_next = bc_reg + 4'd1;
                end
                // Re-arbitrate in the same cycle so back-to-back grants have no bubble.
                if (release_grant) begin
                    p_next  = rr_ptr;
                    bc_next = '0;
                    if (|i_req_valid) begin
                        g_next = pick_from(i_req_valid, rr_ptr);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            g_reg     <= '0;
            p_reg     <= '0;
            bc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            g_reg     <= g_next;
            p_reg     <= p_next;
            bc_reg    <= bc_next;
        end
    end

endmodule
